bp_delta_accumulator: RTL and testbench
=======================================

Name: bp_delta_accumulator

Overview:
- Storage and sequencing partner for the BP processor set's partial-delta interface.
- Reads stored partial delp values and drives them to the BP set as its partial_d input.
- Writes back the returned deltap results.
- Once every contribution for a junction has been accumulated, streams the completed p-layer delp values out, z per beat, to the preceding junction's BP/UP logic.
- Contains z lane banks, a 4-state FSM and a drain handshake.

Parameters:
- fo, 2, fan-out of p-layer neurons (contributions per delp entry)
- p, 16, neurons in the preceding layer
- z, 8, lanes processed per cycle; p must be a multiple of z
- width, 16, fixed-point word width
- D, p/z, derived: depth of each lane bank
- AW, $clog2(D) (minimum 1), derived: lane address width

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- start  in  1  begin a new accumulation pass (sampled in IDLE only)
- acc_valid  in  1  lane addresses valid this cycle
- acc_last  in  1  qualifies acc_valid; final accumulation cycle of the pass
- acc_addr_package  in  z*AW  per-lane bank address; lane k in bits [AW*(k+1)-1:AW*k]
- partial_d_package  out  width*z  stored partial delp per lane, to the BP set
- pd_valid  out  1  partial_d_package valid; deltap_package sampled this cycle
- deltap_package  in  width*z  BP set result, combinational from partial_d_package
- out_valid  out  1  drain beat valid
- out_ready  in  1  downstream accepts drain beat
- out_row  out  AW  bank row of the current drain beat
- out_package  out  width*z  completed delp values, lane k = entry k*D+out_row
- busy  out  1  high in CLEAR, ACCUM and DRAIN

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - FSM -> CLEAR; pd_valid=0, out_valid=0, out_row=0, out_package=0, partial_d_package=0, busy=1.
  - In-flight accumulation is discarded.
- CLEAR:
  - Writes zero to row r of every bank, r=0..D-1, one row per cycle.
  - After D cycles -> IDLE.
- IDLE:
  - busy=0.
  - start=1 -> ACCUM.
  - acc_valid is ignored.
- ACCUM:
  - Read pipeline, latency 1:
    - acc_valid at cycle t registers each lane's bank[addr].
    - At t+1: partial_d_package = registered values, pd_valid=1.
    - At the end of t+1: bank[lane][addr_t] <= deltap_package lane.
  - Back-to-back hazard:
    - Condition: acc_valid at t and t+1 with the same lane address.
    - The t+1 read register takes that cycle's deltap lane (write forwarding), never the stale bank value.
    - Hazard detection and forwarding are independent per lane.
  - acc_valid with acc_last accepted at t:
    - Write at t+1 completes.
    - -> DRAIN at t+2.
  - start in ACCUM is ignored.
- DRAIN:
  - out_row starts at 0; out_package is the combinational/registered read of row out_row.
  - out_valid=1.
  - On out_valid & out_ready:
    - Row out_row is zeroed (clear-on-drain).
    - out_row increments.
  - Last row accepted -> IDLE, out_valid=0, out_row=0.
  - out_ready low holds out_row and out_package stable.
  - acc_valid is ignored.
- No arithmetic in this block; values are stored and forwarded bit-exact.
- Reset asserted in any state overrides everything and returns to CLEAR.

Optional Feature:
- Macro: BP_DELTA_ACC_CNT_EN
- Defined:
  - Adds a per-entry hit counter, width $clog2(fo+1), saturating at fo.
  - Counters are zeroed with their entry in CLEAR and on drain; each counter increments on each write to its entry.
  - Adds output port cnt_err (1 bit), registered and sticky until the next start or reset.
  - cnt_err is set if any drained entry has count != fo, or if a write hits an entry whose count is already fo.
- Not defined:
  - No counters and no cnt_err port.
  - Datapath and timing are identical.

Decomposition:
- Shared package:
  - Derived constants D and AW, plus the counter width.
  - FSM state enum CLEAR/IDLE/ACCUM/DRAIN.
  - Localparam for the lane slice helper.
- Sub-module delta_lane_bank:
  - One lane's D x width storage, registered read, write port and forwarding mux.
  - Optional counter array.
  - Instantiated z times in a generate loop.

Test Plan (p=16, z=8, fo=2, width=16, D=2; BP set modelled as deltap = partial_d + 16'h0400):
- Reset then start, idle 2 cycles -> busy high 2 cycles after reset, then 0; out_valid=0 throughout.
- Row 0 then row 1 on all lanes, each twice in non-consecutive cycles, acc_last on the 4th -> drain yields 2 beats, every lane 16'h0800; out_row 0 then 1.
- Lane 3 addr 0 on 2 consecutive cycles -> second partial_d lane 3 = 16'h0400 (forwarded, not 0); final drained value 16'h0800.
- Drain with out_ready low for 3 cycles -> out_package/out_row stable; after the pass, a second pass with 1 hit per entry drains 16'h0400 (memory was cleared).
- Reset asserted mid-ACCUM -> pd_valid=0 next cycle, CLEAR for 2 cycles, subsequent pass results unaffected by earlier writes.
- BP_DELTA_ACC_CNT_EN, entry lane0/row1 hit once only -> cnt_err=1 on its drain beat, cleared by next start.

Source files
------------

// File: rtl/bp_delta_accumulator_pkg.sv
// Shared definitions for the BP partial-delta accumulator: default geometry,
// FSM state encoding and the small sizing/slicing helpers.
// Optional hit counters are enabled with the macro BP_DELTA_ACC_CNT_EN.
package bp_delta_accumulator_pkg;

    // Base bit offset of lane 0 inside every packed per-lane bus
    localparam int LANE0_LSB = 0;

    // Lane address width: at least one bit even for a single-row bank
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Hit counter width able to hold the value fo
    function automatic int cnt_width(input int fo_n);
        return (fo_n > 0) ? $clog2(fo_n + 1) : 1;
    endfunction

    // LSB of lane 'lane' in a packed bus of slice_w-bit lanes
    function automatic int lane_lsb(input int lane, input int slice_w);
        return LANE0_LSB + lane * slice_w;
    endfunction

    localparam int DEF_FO    = 2;
    localparam int DEF_P     = 16;
    localparam int DEF_Z     = 8;
    localparam int DEF_WIDTH = 16;
    localparam int DEF_D     = DEF_P / DEF_Z;
    localparam int DEF_AW    = addr_width(DEF_D);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_ACCUM = 2'd2,
        ST_DRAIN = 2'd3
    } acc_state_e;

endpackage

// File: rtl/bp_delta_accumulator_if.sv
// Bus bundle between the accumulator (slave) and its environment (master):
// the BP set partial-delta exchange, the accumulation control and the drain.
//
// Handshakes: acc_valid is a one-sided strobe (the accumulator always
// accepts while in ACCUM). The drain is a strict valid/ready pair: a beat
// transfers on a clock edge where out_valid & out_ready are both high;
// while out_valid is high and out_ready low, out_row and out_package hold.
interface bp_delta_accumulator_if #(
    parameter int z     = 8,
    parameter int width = 16,
    parameter int aw    = 1
) ();
    logic                 start;
    logic                 acc_valid;
    logic                 acc_last;
    logic [z*aw-1:0]      acc_addr_package;
    logic [width*z-1:0]   partial_d_package;
    logic                 pd_valid;
    logic [width*z-1:0]   deltap_package;
    logic                 out_valid;
    logic                 out_ready;
    logic [aw-1:0]        out_row;
    logic [width*z-1:0]   out_package;
    logic                 busy;

    modport slave (
        input  start, acc_valid, acc_last, acc_addr_package, deltap_package, out_ready,
        output partial_d_package, pd_valid, out_valid, out_row, out_package, busy
    );

    modport master (
        output start, acc_valid, acc_last, acc_addr_package, deltap_package, out_ready,
        input  partial_d_package, pd_valid, out_valid, out_row, out_package, busy
    );
endinterface

// File: rtl/bp_delta_accumulator_delta_lane_bank.sv
// One lane of delp storage: D x width words, a registered read with
// write-to-read forwarding, one write port and a zeroing port.
// With BP_DELTA_ACC_CNT_EN defined each entry also carries a saturating hit
// counter used for the contribution-count check.
module delta_lane_bank
    import bp_delta_accumulator_pkg::*;
#(
    parameter int D     = 2,
    parameter int AW    = 1,
    parameter int width = 16
`ifdef BP_DELTA_ACC_CNT_EN
    ,
    parameter int fo    = 2
`endif
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [width-1:0] rd_data,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [width-1:0] wr_data,
    input  logic             clr_en,
    input  logic [AW-1:0]    clr_addr,
    input  logic [AW-1:0]    row_addr,
    output logic [width-1:0] row_data
`ifdef BP_DELTA_ACC_CNT_EN
    ,
    output logic             hit_full,
    output logic             row_bad
`endif
);

    logic [width-1:0] mem [D];
    logic [width-1:0] rd_q;

    // Storage update; zeroing and accumulation writes never coincide because
    // they belong to different FSM states.
    always_ff @(posedge clk) begin
        if (clr_en) begin
            mem[clr_addr] <= '0;
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read; a write landing on the same row this cycle is forwarded
    // so back-to-back hits on one entry never see the stale word.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_q <= '0;
        end else if (rd_en) begin
            rd_q <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
        end
    end

    assign rd_data  = rd_q;
    assign row_data = mem[row_addr];

`ifdef BP_DELTA_ACC_CNT_EN
    localparam int CW = cnt_width(fo);
    localparam logic [CW-1:0] FO_C = CW'(fo);

    logic [CW-1:0] cnt [D];

    // Per-entry hit counters, cleared with their entry and saturating at fo
    always_ff @(posedge clk) begin
        if (clr_en) begin
            cnt[clr_addr] <= '0;
        end else if (wr_en && (cnt[wr_addr] != FO_C)) begin
            cnt[wr_addr] <= cnt[wr_addr] + CW'(1);
        end
    end

    assign hit_full = wr_en && (cnt[wr_addr] == FO_C);
    assign row_bad  = (cnt[row_addr] != FO_C);
`endif

endmodule

// File: rtl/bp_delta_accumulator.sv
// Storage and sequencing partner for the BP processor set: feeds stored
// partial delp words out as partial_d, writes the returned deltap back, and
// once a pass is complete streams the finished p-layer delp rows z per beat.
// Defining BP_DELTA_ACC_CNT_EN adds per-entry hit counters and cnt_err.
module bp_delta_accumulator
    import bp_delta_accumulator_pkg::*;
#(
    parameter int fo    = DEF_FO,
    parameter int p     = DEF_P,
    parameter int z     = DEF_Z,
    parameter int width = DEF_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    bp_delta_accumulator_if.slave bus,
    output acc_state_e            dbg_state
`ifdef BP_DELTA_ACC_CNT_EN
    ,
    output logic                  cnt_err
`endif
);

    localparam int D  = p / z;
    localparam int AW = addr_width(D);
    localparam logic [AW-1:0] LAST_ROW = AW'(D - 1);

    if (((p % z) != 0) || (fo < 1)) begin : g_bad_cfg
        $error("bp_delta_accumulator: p must be a multiple of z and fo must be >= 1");
    end

    acc_state_e         state_q;
    acc_state_e         state_d;
    logic               busy;
    logic               clear_en;
    logic               drain_en;
    logic               accept;
    logic               last_pending;
    logic [AW-1:0]      clr_row_q;
    logic [AW-1:0]      out_row_q;
    logic               s1_valid_q;
    logic               s1_last_q;
    logic [z*AW-1:0]    s1_addr_q;
    logic               wr_en;
    logic               drain_fire;
    logic               zero_en;
    logic [AW-1:0]      zero_row;
    logic [z*width-1:0] pd_pkg;
    logic [z*width-1:0] row_pkg;

    // A pass ends once the write belonging to the acc_last cycle is in flight
    assign last_pending = s1_valid_q & s1_last_q;

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-state control strobes
    always_comb begin
        state_d  = state_q;
        busy     = 1'b1;
        clear_en = 1'b0;
        drain_en = 1'b0;
        accept   = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clear_en = 1'b1;
                if (clr_row_q == LAST_ROW) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                busy = 1'b0;
                if (bus.start) begin
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                accept = bus.acc_valid & ~last_pending;
                if (last_pending) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                drain_en = 1'b1;
                if (bus.out_ready && (out_row_q == LAST_ROW)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    // Writes and drain clears are suppressed on a reset edge so an in-flight
    // accumulation is dropped rather than committed.
    assign wr_en      = s1_valid_q & reset_n;
    assign drain_fire = drain_en & bus.out_ready & reset_n;
    assign zero_en    = clear_en | drain_fire;
    assign zero_row   = clear_en ? clr_row_q : out_row_q;

    // Read-pipeline stage and the clear/drain row counters
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_addr_q  <= '0;
            clr_row_q  <= '0;
            out_row_q  <= '0;
        end else begin
            s1_valid_q <= accept;
            s1_last_q  <= accept & bus.acc_last;
            if (accept) begin
                s1_addr_q <= bus.acc_addr_package;
            end
            if (clear_en) begin
                clr_row_q <= (clr_row_q == LAST_ROW) ? '0 : clr_row_q + AW'(1);
            end
            if (drain_fire) begin
                out_row_q <= (out_row_q == LAST_ROW) ? '0 : out_row_q + AW'(1);
            end
        end
    end

`ifdef BP_DELTA_ACC_CNT_EN
    logic [z-1:0] hit_full;
    logic [z-1:0] row_bad;
    logic         cnt_err_q;

    // Sticky count error, cleared when the next pass starts
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_err_q <= 1'b0;
        end else if ((state_q == ST_IDLE) && bus.start) begin
            cnt_err_q <= 1'b0;
        end else if ((|hit_full) || (drain_fire && (|row_bad))) begin
            cnt_err_q <= 1'b1;
        end
    end

    assign cnt_err = cnt_err_q;
`endif

    for (genvar k = 0; k < z; k++) begin : g_lane
        delta_lane_bank #(
            .D     (D),
            .AW    (AW),
            .width (width)
`ifdef BP_DELTA_ACC_CNT_EN
            ,
            .fo    (fo)
`endif
        ) u_bank (
            .clk      (clk),
            .reset_n  (reset_n),
            .rd_en    (accept),
            .rd_addr  (bus.acc_addr_package[lane_lsb(k, AW) +: AW]),
            .rd_data  (pd_pkg[lane_lsb(k, width) +: width]),
            .wr_en    (wr_en),
            .wr_addr  (s1_addr_q[lane_lsb(k, AW) +: AW]),
            .wr_data  (bus.deltap_package[lane_lsb(k, width) +: width]),
            .clr_en   (zero_en),
            .clr_addr (zero_row),
            .row_addr (out_row_q),
            .row_data (row_pkg[lane_lsb(k, width) +: width])
`ifdef BP_DELTA_ACC_CNT_EN
            ,
            .hit_full (hit_full[k]),
            .row_bad  (row_bad[k])
`endif
        );
    end

    assign bus.partial_d_package = pd_pkg;
    assign bus.pd_valid          = s1_valid_q;
    assign bus.out_valid         = drain_en;
    assign bus.out_row           = out_row_q;
    assign bus.out_package       = drain_en ? row_pkg : '0;
    assign bus.busy              = busy;
    assign dbg_state             = state_q;

endmodule

// File: tb/tb_bp_delta_accumulator.sv
// Bench for bp_delta_accumulator: table-driven directed passes, reset and
// forwarding corner cases, randomized passes against a per-entry model.
// Covers cnt_err too when built with BP_DELTA_ACC_CNT_EN.
module tb_bp_delta_accumulator;
    import bp_delta_accumulator_pkg::*;

    localparam int Z  = DEF_Z;
    localparam int W  = DEF_WIDTH;
    localparam int D  = DEF_D;
    localparam int AW = DEF_AW;
    localparam int PW = Z * W;
    localparam int XW = Z * AW;

    typedef struct {
        logic          first;
        logic [XW-1:0] addr;
        logic          last;
        int            gap;
        logic          stall;
        logic [PW-1:0] exp_pd;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    acc_state_e dbg_state;
`ifdef BP_DELTA_ACC_CNT_EN
    logic cnt_err;
`endif

    bp_delta_accumulator_if #(.z(Z), .width(W), .aw(AW)) bus ();

    bp_delta_accumulator #(.fo(DEF_FO), .p(DEF_P), .z(Z), .width(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
`ifdef BP_DELTA_ACC_CNT_EN
        ,
        .cnt_err   (cnt_err)
`endif
    );

    always #5 clk = ~clk;

    // Stand-in for the BP processor set: deltap = partial_d + bp_inc per lane
    logic [W-1:0]  bp_inc = 16'h0400;
    logic [PW-1:0] deltap_model;
    always_comb begin
        deltap_model = '0;
        for (int k = 0; k < Z; k++) begin
            deltap_model[k*W +: W] = bus.partial_d_package[k*W +: W] + bp_inc;
        end
    end
    assign bus.deltap_package = deltap_model;

    int n_checks = 0;
    int n_fail   = 0;
    logic [PW-1:0] exp_q[$];
    logic [W-1:0]  model_mem [Z][D];
    vec_t          tbl [10];

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] rep(input logic [W-1:0] v);
        return {Z{v}};
    endfunction

    function automatic logic [PW-1:0] lane_only(input int lane, input logic [W-1:0] v);
        return PW'(v) << (lane * W);
    endfunction

    function automatic logic [PW-1:0] model_row(input int r);
        logic [PW-1:0] e;
        for (int k = 0; k < Z; k++) e[k*W +: W] = model_mem[k][r];
        return e;
    endfunction

    task automatic model_zero();
        for (int k = 0; k < Z; k++)
            for (int r = 0; r < D; r++) model_mem[k][r] = '0;
    endtask

    // Scoreboard: every pd_valid beat must match the oldest expected word
    always @(negedge clk) begin
        if (reset_n && bus.pd_valid) begin
            if (exp_q.size() == 0) check("pd_unexpected", PW'(1), PW'(0));
            else check("partial_d", bus.partial_d_package, exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        bus.start = 1'b0;
        bus.acc_valid = 1'b0;
        bus.acc_last = 1'b0;
        bus.acc_addr_package = '0;
        bus.out_ready = 1'b0;
        tick();
        exp_q.delete();
        model_zero();
        check("rst_pd_valid", PW'(bus.pd_valid), PW'(0));
        check("rst_out_valid", PW'(bus.out_valid), PW'(0));
        check("rst_out_row", PW'(bus.out_row), PW'(0));
        check("rst_out_package", bus.out_package, PW'(0));
        check("rst_partial_d", bus.partial_d_package, PW'(0));
        check("rst_busy", PW'(bus.busy), PW'(1));
        check("rst_state", PW'(dbg_state), PW'(ST_CLEAR));
        tick();
        reset_n = 1'b1;
        tick();
        check("clear_busy_1", PW'(bus.busy), PW'(1));
        check("clear_out_valid", PW'(bus.out_valid), PW'(0));
        tick();
        check("clear_busy_done", PW'(bus.busy), PW'(0));
    endtask

    task automatic start_pass();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("start_busy", PW'(bus.busy), PW'(1));
    endtask

    // One accumulation cycle; the model supplies (or the table overrides)
    // the expected partial_d, then each addressed entry gains bp_inc.
    task automatic do_op(input logic [XW-1:0] addr, input logic last,
                         input logic use_tbl, input logic [PW-1:0] tbl_exp);
        logic [PW-1:0] e;
        logic [AW-1:0] a;
        for (int k = 0; k < Z; k++) begin
            a = addr[k*AW +: AW];
            e[k*W +: W] = model_mem[k][a];
            model_mem[k][a] = model_mem[k][a] + bp_inc;
        end
        exp_q.push_back(use_tbl ? tbl_exp : e);
        bus.acc_valid = 1'b1;
        bus.acc_last = last;
        bus.acc_addr_package = addr;
        tick();
        bus.acc_valid = 1'b0;
        bus.acc_last = 1'b0;
    endtask

    // Drain every row, called right after the acc_last cycle was accepted
    task automatic drain_pass(input logic stall_first, input logic rand_stall);
        int guard;
        int n_stall;
        logic [PW-1:0] e;
        for (int r = 0; r < D; r++) begin
            guard = 0;
            @(negedge clk);
            while (!bus.out_valid && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            check("drain_out_valid", PW'(bus.out_valid), PW'(1));
            if (!bus.out_valid) return;
            if (r == 0) check("drain_latency", PW'(guard), PW'(1));
            e = model_row(r);
            check("drain_out_row", PW'(bus.out_row), PW'(r));
            check("drain_out_package", bus.out_package, e);
            n_stall = (stall_first && r == 0) ? 3 : (rand_stall ? $urandom_range(0, 2) : 0);
            for (int s = 0; s < n_stall; s++) begin
                @(negedge clk);
                check("stall_out_row", PW'(bus.out_row), PW'(r));
                check("stall_out_package", bus.out_package, e);
            end
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
            for (int k = 0; k < Z; k++) model_mem[k][r] = '0;
        end
        @(negedge clk);
        check("post_drain_out_valid", PW'(bus.out_valid), PW'(0));
        check("post_drain_out_row", PW'(bus.out_row), PW'(0));
        check("post_drain_busy", PW'(bus.busy), PW'(0));
        tick();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no completion expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [XW-1:0] ra;
        int nops;

        model_zero();
        apply_reset();

        // IDLE: not busy, no drain, acc_valid ignored
        repeat (2) begin
            tick();
            check("idle_busy", PW'(bus.busy), PW'(0));
            check("idle_out_valid", PW'(bus.out_valid), PW'(0));
        end
        bus.acc_valid = 1'b1;
        tick();
        bus.acc_valid = 1'b0;
        tick();
        check("idle_ignores_acc", PW'(bus.pd_valid), PW'(0));

        // Directed passes: each row twice per lane, forwarding, one hit per entry
        tbl[0] = '{1'b1, 8'h00, 1'b0, 1, 1'b0, rep(16'h0000)};
        tbl[1] = '{1'b0, 8'hFF, 1'b0, 1, 1'b0, rep(16'h0000)};
        tbl[2] = '{1'b0, 8'h00, 1'b0, 1, 1'b0, rep(16'h0400)};
        tbl[3] = '{1'b0, 8'hFF, 1'b1, 0, 1'b0, rep(16'h0400)};
        tbl[4] = '{1'b1, 8'h00, 1'b0, 0, 1'b1, rep(16'h0000)};
        tbl[5] = '{1'b0, 8'hF7, 1'b1, 0, 1'b1, lane_only(3, 16'h0400)};
        tbl[6] = '{1'b1, 8'h00, 1'b0, 1, 1'b0, rep(16'h0000)};
        tbl[7] = '{1'b0, 8'hFF, 1'b1, 0, 1'b0, rep(16'h0000)};
        bp_inc = 16'h0400;
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].first) start_pass();
            do_op(tbl[i].addr, tbl[i].last, 1'b1, tbl[i].exp_pd);
            if (i == 5) check("fwd_model_lane3", model_row(0) & lane_only(3, 16'hFFFF),
                              lane_only(3, 16'h0800));
            repeat (tbl[i].gap) tick();
            if (tbl[i].last) drain_pass(tbl[i].stall, 1'b0);
        end

        // Reset in the middle of ACCUM drops the pass and clears memory
        start_pass();
        do_op(8'h00, 1'b0, 1'b0, '0);
        do_op(8'hFF, 1'b0, 1'b0, '0);
        apply_reset();
        start_pass();
        do_op(8'h00, 1'b0, 1'b0, '0);
        tick();
        do_op(8'hFF, 1'b1, 1'b0, '0);
        drain_pass(1'b0, 1'b0);

        // Randomized passes
        for (int pass = 0; pass < 6; pass++) begin
            bp_inc = W'($urandom);
            start_pass();
            nops = $urandom_range(1, 10);
            for (int n = 0; n < nops; n++) begin
                for (int k = 0; k < Z; k++) ra[k*AW +: AW] = AW'($urandom_range(0, D - 1));
                do_op(ra, (n == nops - 1), 1'b0, '0);
                if (n != nops - 1) repeat ($urandom_range(0, 2)) tick();
            end
            drain_pass(1'b0, 1'b1);
        end

`ifdef BP_DELTA_ACC_CNT_EN
        // lane0/row1 hit once only; lane0/row0 gets a third hit
        bp_inc = 16'h0400;
        start_pass();
        check("cnt_err_start", PW'(cnt_err), PW'(0));
        do_op(8'h00, 1'b0, 1'b0, '0);
        tick();
        do_op(8'hFF, 1'b0, 1'b0, '0);
        tick();
        do_op(8'h00, 1'b0, 1'b0, '0);
        tick();
        do_op(8'hFE, 1'b1, 1'b0, '0);
        drain_pass(1'b0, 1'b0);
        check("cnt_err_set", PW'(cnt_err), PW'(1));
        start_pass();
        check("cnt_err_cleared", PW'(cnt_err), PW'(0));
        do_op(8'h00, 1'b0, 1'b0, '0);
        tick();
        do_op(8'hFF, 1'b0, 1'b0, '0);
        tick();
        do_op(8'h00, 1'b0, 1'b0, '0);
        tick();
        do_op(8'hFF, 1'b1, 1'b0, '0);
        drain_pass(1'b0, 1'b0);
        check("cnt_err_clean_pass", PW'(cnt_err), PW'(0));
`endif

        check("scoreboard_empty", PW'(exp_q.size()), PW'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
